// File: rtl/color_tracker_pkg.sv
// color_tracker_pkg
// Shared types for the colour tracker: FSM state encoding, aim-point mode
// and an absolute-difference helper used by the deadband filter.
package color_tracker_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EVAL   = 3'd1,
    DIV_X  = 3'd2,
    DIV_Y  = 3'd3,
    UPDATE = 3'd4
  } state_t;

  typedef enum logic {
    MODE_BBOX     = 1'b0,
    MODE_CENTROID = 1'b1
  } center_mode_t;

  function automatic logic [15:0] abs_diff(input logic [15:0] a, input logic [15:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/color_tracker_seq_divider.sv
// seq_divider
// Restoring unsigned divider, one quotient bit per cycle. The first bit is
// resolved on the start edge itself, so a division occupies DW cycles from
// the start edge to the last step; done pulses for one cycle afterwards and
// quotient holds until the next start.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start                 begin a division (ignored while busy)
//   dividend [DW-1:0]     numerator
//   divisor  [VW-1:0]     denominator
//   busy                  steps still outstanding
//   done                  one-cycle pulse, quotient valid
//   quotient [DW-1:0]     result
module seq_divider #(
  parameter int DW = 29,
  parameter int VW = 19
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient
);

  localparam int CW = $clog2(DW + 1);

  logic [VW-1:0] rem;
  logic [DW-1:0] quo;
  logic [CW-1:0] cnt;

  logic          start_ok;
  logic [VW-1:0] src_rem;
  logic [DW-1:0] src_quo;
  logic [VW:0]   trial;
  logic [VW:0]   diff;
  logic [VW-1:0] step_rem;
  logic [DW-1:0] step_quo;

  assign start_ok = start & ~busy;

  // The dividend shifts out of quo MSB-first while quotient bits shift in.
  always_comb begin
    src_rem  = start_ok ? '0 : rem;
    src_quo  = start_ok ? dividend : quo;
    trial    = {src_rem, src_quo[DW-1]};
    diff     = trial - {1'b0, divisor};
    step_rem = trial[VW-1:0];
    step_quo = {src_quo[DW-2:0], 1'b0};
    if (trial >= {1'b0, divisor}) begin
      step_rem = diff[VW-1:0];
      step_quo = {src_quo[DW-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem  <= '0;
      quo  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_ok) begin
        rem  <= step_rem;
        quo  <= step_quo;
        cnt  <= CW'(DW - 1);
        busy <= 1'b1;
      end else if (busy) begin
        rem <= step_rem;
        quo <= step_quo;
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo;

endmodule

// File: rtl/color_tracker.sv
// color_tracker
// Classifies RGB565 pixels against runtime thresholds, accumulates bbox,
// count and coordinate sums per frame, and on each v_sync rising edge
// produces a deadband-filtered aim point (bbox midpoint or centroid) with
// a frame-based lost-target flag.
// Ports:
//   clk, reset                       pixel clock, async active-high reset
//   v_sync, DE, x_pixel, y_pixel     video timing and coordinate
//   data                             RGB565 pixel
//   r_min, g_max, b_max              colour thresholds (R>, G<, B<)
//   centroid_mode                    0 bbox midpoint, 1 centroid
//   aim_x, aim_y, aim_detected       filtered aim point and detection flag
//   x/y_min_out, x/y_max_out         last detected bounding box
//   pixel_count_out                  matched pixels in last frame
//   frame_done, frame_overrun        one-cycle status pulses
//   target_off                       lost-target flag
//
// state  | meaning
// IDLE   | accumulating pixels, waiting for frame boundary
// EVAL   | detection test; bbox midpoint or launch X division
// DIV_X  | centroid X division in progress
// DIV_Y  | centroid Y division in progress
// UPDATE | apply deadband, latch outputs, pulse frame_done
module color_tracker
  import color_tracker_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int COORD_W     = 10,
  parameter int CNT_W       = 19,
  parameter int EDGE_MARGIN = 10,
  parameter int MIN_PIXELS  = 50,
  parameter int DEADBAND    = 10,
  parameter int LOST_FRAMES = 180
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               v_sync,
  input  logic               DE,
  input  logic [COORD_W-1:0] x_pixel,
  input  logic [COORD_W-1:0] y_pixel,
  input  logic [15:0]        data,
  input  logic [4:0]         r_min,
  input  logic [5:0]         g_max,
  input  logic [4:0]         b_max,
  input  logic               centroid_mode,
  output logic [COORD_W-1:0] aim_x,
  output logic [COORD_W-1:0] aim_y,
  output logic               aim_detected,
  output logic [COORD_W-1:0] x_min_out,
  output logic [COORD_W-1:0] x_max_out,
  output logic [COORD_W-1:0] y_min_out,
  output logic [COORD_W-1:0] y_max_out,
  output logic [CNT_W-1:0]   pixel_count_out,
  output logic               frame_done,
  output logic               frame_overrun,
  output logic               target_off
);

  localparam int SUM_W  = CNT_W + COORD_W;
  localparam int LOST_W = $clog2(LOST_FRAMES + 1);
  localparam logic [COORD_W-1:0] X_LO   = COORD_W'(EDGE_MARGIN);
  localparam logic [COORD_W-1:0] X_HI   = COORD_W'(H_ACTIVE - EDGE_MARGIN);
  localparam logic [COORD_W-1:0] AIM_X0 = COORD_W'(H_ACTIVE / 2);
  localparam logic [COORD_W-1:0] AIM_Y0 = COORD_W'(V_ACTIVE / 2);
  localparam logic [CNT_W-1:0]   MIN_CNT  = CNT_W'(MIN_PIXELS);
  localparam logic [15:0]        DB       = 16'(DEADBAND);
  localparam logic [LOST_W-1:0]  LOST_MAX = LOST_W'(LOST_FRAMES);

  state_t state, next_state;

  logic vsync_d, vsync_start, match;
  logic [COORD_W-1:0] acc_xmin, acc_xmax, acc_ymin, acc_ymax;
  logic [CNT_W-1:0]   acc_cnt;
  logic [SUM_W-1:0]   acc_sx, acc_sy;

  logic [COORD_W-1:0] snap_xmin, snap_xmax, snap_ymin, snap_ymax;
  logic [CNT_W-1:0]   snap_cnt;
  logic [SUM_W-1:0]   snap_sx, snap_sy;
  center_mode_t       snap_mode;
  logic               snap_det;

  logic [COORD_W-1:0] center_x, center_y, div_center;
  logic [COORD_W:0]   mid_x, mid_y;
  logic [LOST_W-1:0]  lost_cnt;
  logic               seen_target, jump;

  logic             div_start, div_busy, div_done;
  logic [SUM_W-1:0] div_dividend, div_quotient;

  assign vsync_start = v_sync & ~vsync_d;
  assign match = DE & (data[15:11] > r_min) & (data[10:5] < g_max) & (data[4:0] < b_max)
               & (x_pixel > X_LO) & (x_pixel < X_HI);
  assign snap_det = snap_cnt > MIN_CNT;
  assign mid_x = {1'b0, snap_xmin} + {1'b0, snap_xmax};
  assign mid_y = {1'b0, snap_ymin} + {1'b0, snap_ymax};
  // A centroid can never exceed the coordinate range; clamp defensively.
  assign div_center = (|div_quotient[SUM_W-1:COORD_W]) ? '1 : div_quotient[COORD_W-1:0];
  assign jump = target_off | ~seen_target;
  assign div_dividend = (state == EVAL) ? snap_sx : snap_sy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_d  <= 1'b0;
      acc_xmin <= '1;
      acc_ymin <= '1;
      acc_xmax <= '0;
      acc_ymax <= '0;
      acc_cnt  <= '0;
      acc_sx   <= '0;
      acc_sy   <= '0;
    end else begin
      vsync_d <= v_sync;
      // The boundary cycle clears the accumulators and drops its own pixel.
      if (vsync_start) begin
        acc_xmin <= '1;
        acc_ymin <= '1;
        acc_xmax <= '0;
        acc_ymax <= '0;
        acc_cnt  <= '0;
        acc_sx   <= '0;
        acc_sy   <= '0;
      end else if (match) begin
        if (acc_cnt != '1) acc_cnt <= acc_cnt + 1'b1;
        if (x_pixel < acc_xmin) acc_xmin <= x_pixel;
        if (x_pixel > acc_xmax) acc_xmax <= x_pixel;
        if (y_pixel < acc_ymin) acc_ymin <= y_pixel;
        if (y_pixel > acc_ymax) acc_ymax <= y_pixel;
        acc_sx <= acc_sx + SUM_W'(x_pixel);
        acc_sy <= acc_sy + SUM_W'(y_pixel);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_xmin <= '0;
      snap_xmax <= '0;
      snap_ymin <= '0;
      snap_ymax <= '0;
      snap_cnt  <= '0;
      snap_sx   <= '0;
      snap_sy   <= '0;
      snap_mode <= MODE_BBOX;
    end else if (vsync_start && state == IDLE) begin
      snap_xmin <= acc_xmin;
      snap_xmax <= acc_xmax;
      snap_ymin <= acc_ymin;
      snap_ymax <= acc_ymax;
      snap_cnt  <= acc_cnt;
      snap_sx   <= acc_sx;
      snap_sy   <= acc_sy;
      snap_mode <= center_mode_t'(centroid_mode);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // X is launched from EVAL; Y is launched from the first DIV_Y cycle once
  // the divider has gone idle, giving 2*D+3 cycles boundary-to-done.
  always_comb begin
    next_state = state;
    div_start  = 1'b0;
    case (state)
      IDLE:   if (vsync_start) next_state = EVAL;
      EVAL: begin
        if (!snap_det || snap_mode == MODE_BBOX) begin
          next_state = UPDATE;
        end else begin
          div_start  = 1'b1;
          next_state = DIV_X;
        end
      end
      DIV_X:  if (div_done) next_state = DIV_Y;
      DIV_Y: begin
        div_start = ~div_busy & ~div_done;
        if (div_done) next_state = UPDATE;
      end
      UPDATE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  seq_divider #(.DW(SUM_W), .VW(CNT_W)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (snap_cnt),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aim_x           <= AIM_X0;
      aim_y           <= AIM_Y0;
      aim_detected    <= 1'b0;
      x_min_out       <= '0;
      x_max_out       <= '0;
      y_min_out       <= '0;
      y_max_out       <= '0;
      pixel_count_out <= '0;
      frame_done      <= 1'b0;
      frame_overrun   <= 1'b0;
      target_off      <= 1'b0;
      center_x        <= '0;
      center_y        <= '0;
      lost_cnt        <= '0;
      seen_target     <= 1'b0;
    end else begin
      frame_done    <= 1'b0;
      frame_overrun <= vsync_start & (state != IDLE);
      case (state)
        EVAL: begin
          if (!snap_det) begin
            aim_detected <= 1'b0;
            if (lost_cnt != LOST_MAX) lost_cnt <= lost_cnt + 1'b1;
          end else if (snap_mode == MODE_BBOX) begin
            center_x <= mid_x[COORD_W:1];
            center_y <= mid_y[COORD_W:1];
          end
        end
        DIV_X: if (div_done) center_x <= div_center;
        DIV_Y: if (div_done) center_y <= div_center;
        UPDATE: begin
          frame_done      <= 1'b1;
          pixel_count_out <= snap_cnt;
          if (snap_det) begin
            aim_detected <= 1'b1;
            lost_cnt     <= '0;
            target_off   <= 1'b0;
            seen_target  <= 1'b1;
            x_min_out    <= snap_xmin;
            x_max_out    <= snap_xmax;
            y_min_out    <= snap_ymin;
            y_max_out    <= snap_ymax;
            if (jump || abs_diff(16'(center_x), 16'(aim_x)) > DB) aim_x <= center_x;
            if (jump || abs_diff(16'(center_y), 16'(aim_y)) > DB) aim_y <= center_y;
          end else begin
            target_off <= (lost_cnt >= LOST_MAX);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_color_tracker.sv
// tb_color_tracker
// Directed bench for color_tracker (LOST_FRAMES overridden to 3). Each task
// drives one scenario and checks outputs against hand-computed values.
module tb_color_tracker;

  logic        clk = 1'b0;
  logic        reset;
  logic        v_sync, DE;
  logic [9:0]  x_pixel, y_pixel;
  logic [15:0] data;
  logic [4:0]  r_min, b_max;
  logic [5:0]  g_max;
  logic        centroid_mode;
  logic [9:0]  aim_x, aim_y, x_min_out, x_max_out, y_min_out, y_max_out;
  logic        aim_detected, frame_done, frame_overrun, target_off;
  logic [18:0] pixel_count_out;

  int assertions = 0;
  int failures   = 0;

  localparam logic [15:0] RED = 16'hF800;  // R31 G0 B0
  localparam logic [15:0] G15 = 16'hF9E0;  // R31 G15 B0 -> rejected
  localparam logic [15:0] R20 = 16'hA000;  // R20 -> rejected
  localparam logic [15:0] B15 = 16'hF80F;  // R31 B15 -> rejected
  localparam logic [15:0] R21 = 16'hA9CE;  // R21 G14 B14 -> accepted

  color_tracker #(.LOST_FRAMES(3)) dut (
    .clk(clk), .reset(reset), .v_sync(v_sync), .DE(DE),
    .x_pixel(x_pixel), .y_pixel(y_pixel), .data(data),
    .r_min(r_min), .g_max(g_max), .b_max(b_max), .centroid_mode(centroid_mode),
    .aim_x(aim_x), .aim_y(aim_y), .aim_detected(aim_detected),
    .x_min_out(x_min_out), .x_max_out(x_max_out),
    .y_min_out(y_min_out), .y_max_out(y_max_out),
    .pixel_count_out(pixel_count_out), .frame_done(frame_done),
    .frame_overrun(frame_overrun), .target_off(target_off)
  );

  always #5 clk = ~clk;

  task automatic pix(input int x, input int y, input logic [15:0] d, input logic de);
    x_pixel = 10'(x);
    y_pixel = 10'(y);
    data    = d;
    DE      = de;
    @(posedge clk); #1;
    DE = 1'b0;
  endtask

  task automatic rect(input int x0, input int x1, input int y0, input int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        pix(x, y, RED, 1'b1);
  endtask

  task automatic l_shape();
    rect(106, 115, 50, 89);
    rect(116, 155, 80, 89);
  endtask

  // Raise v_sync for one cycle and count edges after the boundary edge
  // until frame_done is seen (300 means it never came).
  task automatic run_frame(output int n);
    v_sync = 1'b1;
    @(posedge clk); #1;
    v_sync = 1'b0;
    n = 0;
    while (n < 300) begin
      @(posedge clk); #1;
      n++;
      if (frame_done) break;
    end
    if (n >= 300) n = 300;
  endtask

  task automatic test_reset();
    assertions++; if (aim_x !== 10'd320) begin failures++; $display("FAIL reset aim_x got %0d want 320", aim_x); end
    assertions++; if (aim_y !== 10'd240) begin failures++; $display("FAIL reset aim_y got %0d want 240", aim_y); end
    assertions++; if ({aim_detected, frame_done, frame_overrun, target_off} !== 4'b0) begin failures++; $display("FAIL reset flags got %b want 0000", {aim_detected, frame_done, frame_overrun, target_off}); end
    assertions++; if (pixel_count_out !== 19'd0 || x_max_out !== 10'd0) begin failures++; $display("FAIL reset count/bbox got %0d/%0d want 0/0", pixel_count_out, x_max_out); end
  endtask

  task automatic test_bbox();
    int n;
    centroid_mode = 1'b0;
    rect(100, 199, 50, 149);
    run_frame(n);
    assertions++; if (n !== 2) begin failures++; $display("FAIL bbox latency got %0d want 2", n); end
    assertions++; if (aim_x !== 10'd149 || aim_y !== 10'd99) begin failures++; $display("FAIL bbox aim got (%0d,%0d) want (149,99)", aim_x, aim_y); end
    assertions++; if ({x_min_out, x_max_out, y_min_out, y_max_out} !== {10'd100, 10'd199, 10'd50, 10'd149}) begin failures++; $display("FAIL bbox box got %0d/%0d/%0d/%0d want 100/199/50/149", x_min_out, x_max_out, y_min_out, y_max_out); end
    assertions++; if (pixel_count_out !== 19'd10000) begin failures++; $display("FAIL bbox count got %0d want 10000", pixel_count_out); end
    assertions++; if (aim_detected !== 1'b1) begin failures++; $display("FAIL bbox detected got %b want 1", aim_detected); end
    @(posedge clk); #1;
    assertions++; if (frame_done !== 1'b0) begin failures++; $display("FAIL bbox done_pulse got %b want 0", frame_done); end
  endtask

  task automatic test_deadband();
    int n;
    rect(108, 207, 58, 157);
    run_frame(n);
    assertions++; if (aim_x !== 10'd149 || aim_y !== 10'd99) begin failures++; $display("FAIL deadband8 aim got (%0d,%0d) want (149,99)", aim_x, aim_y); end
    assertions++; if (x_min_out !== 10'd108) begin failures++; $display("FAIL deadband8 x_min got %0d want 108", x_min_out); end
    rect(111, 210, 61, 160);
    run_frame(n);
    assertions++; if (aim_x !== 10'd160 || aim_y !== 10'd110) begin failures++; $display("FAIL deadband11 aim got (%0d,%0d) want (160,110)", aim_x, aim_y); end
  endtask

  task automatic test_centroid();
    int n;
    centroid_mode = 1'b1;
    l_shape();
    run_frame(n);
    assertions++; if (n !== 61) begin failures++; $display("FAIL centroid latency got %0d want 61", n); end
    assertions++; if (aim_x !== 10'd123 || aim_y !== 10'd77) begin failures++; $display("FAIL centroid aim got (%0d,%0d) want (123,77)", aim_x, aim_y); end
    assertions++; if (pixel_count_out !== 19'd800) begin failures++; $display("FAIL centroid count got %0d want 800", pixel_count_out); end
    assertions++; if ({x_min_out, x_max_out, y_min_out, y_max_out} !== {10'd106, 10'd155, 10'd50, 10'd89}) begin failures++; $display("FAIL centroid box got %0d/%0d/%0d/%0d want 106/155/50/89", x_min_out, x_max_out, y_min_out, y_max_out); end
  endtask

  task automatic test_edges();
    int n;
    centroid_mode = 1'b0;
    rect(200, 249, 200, 200);
    pix(5, 200, RED, 1'b1);
    pix(635, 200, RED, 1'b1);
    pix(10, 200, RED, 1'b1);
    pix(630, 200, RED, 1'b1);
    pix(150, 200, G15, 1'b1);
    pix(151, 200, R20, 1'b1);
    pix(152, 200, B15, 1'b1);
    pix(153, 200, RED, 1'b0);
    run_frame(n);
    assertions++; if (n !== 2) begin failures++; $display("FAIL edge50 latency got %0d want 2", n); end
    assertions++; if (aim_detected !== 1'b0) begin failures++; $display("FAIL edge50 detected got %b want 0", aim_detected); end
    assertions++; if (pixel_count_out !== 19'd50) begin failures++; $display("FAIL edge50 count got %0d want 50", pixel_count_out); end
    assertions++; if (aim_x !== 10'd123 || x_min_out !== 10'd106) begin failures++; $display("FAIL edge50 hold got aim_x %0d x_min %0d want 123 106", aim_x, x_min_out); end
    rect(200, 247, 200, 200);
    pix(11, 200, RED, 1'b1);
    pix(629, 200, RED, 1'b1);
    pix(150, 200, R21, 1'b1);
    run_frame(n);
    assertions++; if (aim_detected !== 1'b1 || pixel_count_out !== 19'd51) begin failures++; $display("FAIL edge51 det/count got %b/%0d want 1/51", aim_detected, pixel_count_out); end
    assertions++; if (x_min_out !== 10'd11 || x_max_out !== 10'd629) begin failures++; $display("FAIL edge51 xbox got %0d/%0d want 11/629", x_min_out, x_max_out); end
    assertions++; if (aim_x !== 10'd320 || aim_y !== 10'd200) begin failures++; $display("FAIL edge51 aim got (%0d,%0d) want (320,200)", aim_x, aim_y); end
  endtask

  task automatic test_lost();
    int n;
    logic [2:0] exp_off;
    exp_off = 3'b100;
    for (int f = 0; f < 3; f++) begin
      run_frame(n);
      assertions++; if (target_off !== exp_off[f] || aim_detected !== 1'b0) begin failures++; $display("FAIL lost frame%0d off/det got %b/%b want %b/0", f, target_off, aim_detected, exp_off[f]); end
    end
    rect(322, 326, 198, 208);
    run_frame(n);
    assertions++; if (target_off !== 1'b0 || aim_detected !== 1'b1) begin failures++; $display("FAIL reacquire off/det got %b/%b want 0/1", target_off, aim_detected); end
    assertions++; if (aim_x !== 10'd324 || aim_y !== 10'd203) begin failures++; $display("FAIL reacquire aim got (%0d,%0d) want (324,203)", aim_x, aim_y); end
  endtask

  task automatic test_overrun();
    int n;
    centroid_mode = 1'b1;
    l_shape();
    v_sync = 1'b1;
    @(posedge clk); #1;
    v_sync = 1'b0;
    n = 0;
    repeat (10) begin @(posedge clk); #1; n++; end
    v_sync = 1'b1;
    @(posedge clk); #1;
    n++;
    v_sync = 1'b0;
    assertions++; if (frame_overrun !== 1'b1) begin failures++; $display("FAIL overrun pulse got %b want 1", frame_overrun); end
    assertions++; if (aim_x !== 10'd324 || aim_y !== 10'd203 || frame_done !== 1'b0) begin failures++; $display("FAIL overrun hold got (%0d,%0d) done %b want (324,203) 0", aim_x, aim_y, frame_done); end
    @(posedge clk); #1;
    n++;
    assertions++; if (frame_overrun !== 1'b0) begin failures++; $display("FAIL overrun width got %b want 0", frame_overrun); end
    while (n < 300 && !frame_done) begin @(posedge clk); #1; n++; end
    assertions++; if (n !== 61) begin failures++; $display("FAIL overrun latency got %0d want 61", n); end
    assertions++; if (aim_x !== 10'd123 || aim_y !== 10'd77) begin failures++; $display("FAIL overrun aim got (%0d,%0d) want (123,77)", aim_x, aim_y); end
  endtask

  task automatic test_reset_mid();
    int n;
    int dones;
    centroid_mode = 1'b1;
    rect(300, 309, 100, 109);
    v_sync = 1'b1;
    @(posedge clk); #1;
    v_sync = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    assertions++; if (aim_x !== 10'd320 || aim_y !== 10'd240) begin failures++; $display("FAIL midreset aim got (%0d,%0d) want (320,240)", aim_x, aim_y); end
    assertions++; if ({aim_detected, target_off, frame_done} !== 3'b0 || pixel_count_out !== 19'd0 || x_min_out !== 10'd0) begin failures++; $display("FAIL midreset outs got %b cnt %0d xmin %0d want 000 0 0", {aim_detected, target_off, frame_done}, pixel_count_out, x_min_out); end
    @(posedge clk); #1;
    reset = 1'b0;
    dones = 0;
    repeat (70) begin @(posedge clk); #1; if (frame_done) dones++; end
    assertions++; if (dones !== 0) begin failures++; $display("FAIL midreset stale_done got %0d want 0", dones); end
    centroid_mode = 1'b0;
    rect(322, 326, 238, 248);
    run_frame(n);
    assertions++; if (n !== 2) begin failures++; $display("FAIL postreset latency got %0d want 2", n); end
    assertions++; if (aim_x !== 10'd324 || aim_y !== 10'd243) begin failures++; $display("FAIL postreset aim got (%0d,%0d) want (324,243)", aim_x, aim_y); end
  endtask

  initial begin
    reset = 1'b1;
    v_sync = 1'b0;
    DE = 1'b0;
    x_pixel = '0;
    y_pixel = '0;
    data = '0;
    r_min = 5'd20;
    g_max = 6'd15;
    b_max = 5'd15;
    centroid_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    test_bbox();
    test_deadband();
    test_centroid();
    test_edges();
    test_lost();
    test_overrun();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
